// File: rtl/mby_igr_shim_seg_fifo.sv
// Per-port ingress segment FIFO behind the EPL shim. It compacts 0-3 lanes per
// cycle into one in-order buffer, drains one segment per cycle, and aborts frames on overflow.
module mby_igr_shim_seg_fifo_chk #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          cclk,
  input  logic          rst,
  input  logic [CW-1:0] count,
  input  logic          pop,
  input  logic          sop,
  input  logic          eop,
  input  logic          err
);
  logic out_open;

  // output-side frame tracker: open after a popped sop, closed by a popped eop or abort
  always_ff @(posedge cclk) begin
    if (rst) begin
      out_open <= 1'b0;
    end else if (pop) begin
      if (eop || err) begin
        out_open <= 1'b0;
      end else if (sop) begin
        out_open <= 1'b1;
      end else begin
        out_open <= out_open;
      end
    end else begin
      out_open <= out_open;
    end
  end

  a_count_bound: assert property (@(posedge cclk) disable iff (rst) count <= CW'(DEPTH));
  a_sop_closed:  assert property (@(posedge cclk) disable iff (rst) (pop && sop) |-> !out_open);
endmodule

module mby_igr_shim_seg_fifo #(
  parameter int SEG_W = 576,
  parameter int MD_W  = 64,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   cclk,
  input  logic                   rst,
  input  logic [2:0]             i_seg_v,
  input  logic [3*SEG_W-1:0]     i_seg_data,
  input  logic [3*MD_W-1:0]      i_seg_md,
  input  logic [2:0]             i_seg_sop,
  input  logic [2:0]             i_seg_eop,
  output logic                   o_seg_v,
  output logic [SEG_W-1:0]       o_seg_data,
  output logic [MD_W-1:0]        o_seg_md,
  output logic                   o_seg_sop,
  output logic                   o_seg_eop,
  output logic                   o_seg_err,
  input  logic                   i_pb_rdy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ovf,
  output logic [CNT_W-1:0]       o_drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  function automatic logic [1:0] popcnt3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

  state_t           state, state_nxt;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             pkt_open, pkt_open_nxt;
  logic             abort_pend, abort_pend_nxt;
  logic             ovf_nxt;
  logic [1:0]       drop_add;
  logic [CNT_W:0]   drop_sum;

  logic [SEG_W-1:0] mem_data [DEPTH];
  logic [MD_W-1:0]  mem_md   [DEPTH];
  logic [DEPTH-1:0] mem_sop, mem_eop, mem_err;

  logic [CW-1:0]    free, room;
  logic             pop;
  logic [1:0]       n_in;
  logic [2:0]       sop_v, first_sop, pre_mask, rest_mask;
  logic [2:0]       keep;
  logic             wr_abort;
  logic [2:0]       n_wr;
  logic             open_tmp;
  logic [SEG_W-1:0] slot_data [4];
  logic [MD_W-1:0]  slot_md   [4];
  logic [3:0]       slot_sop, slot_eop, slot_err;

  assign o_seg_v    = (count != '0);
  assign pop        = o_seg_v & i_pb_rdy;
  assign free       = CW'(DEPTH) - count;
  assign n_in       = popcnt3(i_seg_v);
  assign sop_v      = i_seg_v & i_seg_sop;
  // isolate the lowest sop lane; with no sop every valid lane counts as "before sop"
  assign first_sop  = sop_v & (~sop_v + 3'd1);
  assign pre_mask   = i_seg_v & (first_sop - 3'd1);
  assign rest_mask  = i_seg_v & ~pre_mask;

  assign o_seg_data = o_seg_v ? mem_data[rd_ptr] : '0;
  assign o_seg_md   = o_seg_v ? mem_md[rd_ptr]   : '0;
  assign o_seg_sop  = o_seg_v ? mem_sop[rd_ptr]  : 1'b0;
  assign o_seg_eop  = o_seg_v ? mem_eop[rd_ptr]  : 1'b0;
  assign o_seg_err  = o_seg_v ? mem_err[rd_ptr]  : 1'b0;
  assign o_count    = count;
  assign drop_sum   = {1'b0, o_drop_cnt} + (CNT_W+1)'(drop_add);

  // admission decision: which lanes to keep, abort insertion, drops and next state
  always_comb begin
    state_nxt      = state;
    abort_pend_nxt = abort_pend;
    ovf_nxt        = 1'b0;
    drop_add       = 2'd0;
    keep           = 3'b000;
    wr_abort       = 1'b0;
    room           = free;
    case (state)
      ST_ACCEPT: begin
        if (CW'(n_in) <= free) begin
          keep = i_seg_v;
        end else begin
          ovf_nxt   = 1'b1;
          drop_add  = n_in;
          state_nxt = ST_DISCARD;
          if (pkt_open || (sop_v != 3'b000)) begin
            abort_pend_nxt = 1'b1;
          end else begin
            abort_pend_nxt = abort_pend;
          end
        end
      end
      ST_DISCARD: begin
        drop_add = popcnt3(pre_mask);
        if (abort_pend && (free != '0)) begin
          wr_abort       = 1'b1;
          abort_pend_nxt = 1'b0;
          room           = free - CW'(1);
        end else begin
          room = free;
        end
        if (sop_v != 3'b000) begin
          if (!abort_pend_nxt && (CW'(popcnt3(rest_mask)) <= room)) begin
            keep      = rest_mask;
            state_nxt = ST_ACCEPT;
          end else begin
            drop_add = n_in;
            ovf_nxt  = 1'b1;
          end
        end else begin
          keep = 3'b000;
        end
      end
      default: begin
        state_nxt = ST_ACCEPT;
      end
    endcase
  end

  // compaction: abort marker first, then kept lanes in ascending order into consecutive slots
  always_comb begin
    n_wr     = 3'd0;
    open_tmp = wr_abort ? 1'b0 : pkt_open;
    slot_sop = 4'b0000;
    slot_eop = 4'b0000;
    slot_err = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      slot_data[k] = '0;
      slot_md[k]   = '0;
    end
    if (wr_abort) begin
      slot_eop[0] = 1'b1;
      slot_err[0] = 1'b1;
      n_wr        = 3'd1;
    end else begin
      n_wr = 3'd0;
    end
    for (int l = 0; l < 3; l++) begin
      if (keep[l]) begin
        slot_data[n_wr[1:0]] = i_seg_data[l*SEG_W +: SEG_W];
        slot_md[n_wr[1:0]]   = i_seg_md[l*MD_W +: MD_W];
        slot_sop[n_wr[1:0]]  = i_seg_sop[l];
        slot_eop[n_wr[1:0]]  = i_seg_eop[l];
        open_tmp             = i_seg_eop[l] ? 1'b0 : (i_seg_sop[l] ? 1'b1 : open_tmp);
        n_wr                 = n_wr + 3'd1;
      end else begin
        n_wr = n_wr;
      end
    end
    pkt_open_nxt = open_tmp;
  end

  // control state, pointers, occupancy and status outputs
  always_ff @(posedge cclk) begin
    if (rst) begin
      state      <= ST_ACCEPT;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pkt_open   <= 1'b0;
      abort_pend <= 1'b0;
      o_ovf      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      state      <= state_nxt;
      rd_ptr     <= rd_ptr + PW'(pop);
      wr_ptr     <= wr_ptr + PW'(n_wr);
      count      <= count + CW'(n_wr) - CW'(pop);
      pkt_open   <= pkt_open_nxt;
      abort_pend <= abort_pend_nxt;
      o_ovf      <= ovf_nxt;
      o_drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  // segment storage; content is don't-care while the entry is not occupied
  always_ff @(posedge cclk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst && (3'(k) < n_wr)) begin
        mem_data[wr_ptr + PW'(k)] <= slot_data[k];
        mem_md[wr_ptr + PW'(k)]   <= slot_md[k];
        mem_sop[wr_ptr + PW'(k)]  <= slot_sop[k];
        mem_eop[wr_ptr + PW'(k)]  <= slot_eop[k];
        mem_err[wr_ptr + PW'(k)]  <= slot_err[k];
      end
    end
  end

  mby_igr_shim_seg_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .cclk  (cclk),
    .rst   (rst),
    .count (count),
    .pop   (pop),
    .sop   (o_seg_sop),
    .eop   (o_seg_eop),
    .err   (o_seg_err)
  );
endmodule

// File: tb/tb_mby_igr_shim_seg_fifo.sv
// Directed bench for mby_igr_shim_seg_fifo: a queue-based frame model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_mby_igr_shim_seg_fifo;
  localparam int SEG_W = 576;
  localparam int MD_W  = 64;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               cclk = 1'b0;
  logic               rst;
  logic [2:0]         i_seg_v, i_seg_sop, i_seg_eop;
  logic [3*SEG_W-1:0] i_seg_data;
  logic [3*MD_W-1:0]  i_seg_md;
  logic               o_seg_v, o_seg_sop, o_seg_eop, o_seg_err, i_pb_rdy, o_ovf;
  logic [SEG_W-1:0]   o_seg_data;
  logic [MD_W-1:0]    o_seg_md;
  logic [CW-1:0]      o_count;
  logic [CNT_W-1:0]   o_drop_cnt;

  always #5 cclk = ~cclk;

  mby_igr_shim_seg_fifo #(.SEG_W(SEG_W), .MD_W(MD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .cclk(cclk), .rst(rst), .i_seg_v(i_seg_v), .i_seg_data(i_seg_data), .i_seg_md(i_seg_md),
    .i_seg_sop(i_seg_sop), .i_seg_eop(i_seg_eop), .o_seg_v(o_seg_v), .o_seg_data(o_seg_data),
    .o_seg_md(o_seg_md), .o_seg_sop(o_seg_sop), .o_seg_eop(o_seg_eop), .o_seg_err(o_seg_err),
    .i_pb_rdy(i_pb_rdy), .o_count(o_count), .o_ovf(o_ovf), .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    logic [SEG_W-1:0] data;
    logic [MD_W-1:0]  md;
    logic             sop, eop, err;
  } ent_t;

  ent_t mq[$];
  bit   m_disc, m_open, m_abort, m_ovf;
  int   m_drops;
  int   n_vec = 0, n_bad = 0, nid = 0, b;
  bit   chk_en = 1'b0;

  function automatic logic [SEG_W-1:0] mk_data(input int id);
    logic [31:0] w;
    w = id;
    return {18{w}};
  endfunction

  function automatic logic [MD_W-1:0] mk_md(input int id);
    logic [31:0] w;
    w = id;
    return {~w, w};
  endfunction

  task automatic chk_n(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [SEG_W-1:0] act, input logic [SEG_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ent_t lane_ent(input int l);
    ent_t e;
    e.data = i_seg_data[l*SEG_W +: SEG_W];
    e.md   = i_seg_md[l*MD_W +: MD_W];
    e.sop  = i_seg_sop[l];
    e.eop  = i_seg_eop[l];
    e.err  = 1'b0;
    return e;
  endfunction

  // frame-level model: one call per clock edge, from the inputs seen at that edge
  task automatic model_step();
    ent_t nw[$];
    ent_t e;
    int   sz, free, n_in, f, room, rest, dropped;
    bit   pop, ovf;
    if (rst) begin
      mq.delete();
      m_disc = 0; m_open = 0; m_abort = 0; m_ovf = 0; m_drops = 0;
      return;
    end
    sz = mq.size(); free = DEPTH - sz; pop = (sz > 0) && i_pb_rdy;
    n_in = $countones(i_seg_v); dropped = 0; ovf = 0;
    f = 3;
    for (int l = 2; l >= 0; l--) if (i_seg_v[l] && i_seg_sop[l]) f = l;
    if (!m_disc) begin
      if (n_in <= free) begin
        for (int l = 0; l < 3; l++) if (i_seg_v[l]) begin
          nw.push_back(lane_ent(l));
          if (i_seg_sop[l]) m_open = 1;
          if (i_seg_eop[l]) m_open = 0;
        end
      end else begin
        ovf = 1; dropped = n_in; m_disc = 1;
        if (m_open || (i_seg_v & i_seg_sop) != 3'b000) m_abort = 1;
      end
    end else begin
      room = free;
      for (int l = 0; l < f; l++) if (i_seg_v[l]) dropped++;
      if (m_abort && room >= 1) begin
        e.data = '0; e.md = '0; e.sop = 1'b0; e.eop = 1'b1; e.err = 1'b1;
        nw.push_back(e);
        m_abort = 0; m_open = 0; room--;
      end
      if (f < 3) begin
        rest = 0;
        for (int l = f; l < 3; l++) if (i_seg_v[l]) rest++;
        if (!m_abort && rest <= room) begin
          for (int l = f; l < 3; l++) if (i_seg_v[l]) begin
            nw.push_back(lane_ent(l));
            if (i_seg_sop[l]) m_open = 1;
            if (i_seg_eop[l]) m_open = 0;
          end
          m_disc = 0;
        end else begin
          dropped += rest; ovf = 1;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    foreach (nw[i]) mq.push_back(nw[i]);
    m_drops = (m_drops + dropped > 2**CNT_W - 1) ? 2**CNT_W - 1 : m_drops + dropped;
    m_ovf = ovf;
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge cclk) begin
    if (chk_en) begin
      chk_n("o_seg_v", int'(o_seg_v), (mq.size() != 0) ? 1 : 0);
      chk_n("o_count", int'(o_count), mq.size());
      chk_n("o_ovf", int'(o_ovf), int'(m_ovf));
      chk_n("o_drop_cnt", int'(o_drop_cnt), m_drops);
      if (mq.size() != 0) begin
        chk_w("o_seg_data", o_seg_data, mq[0].data);
        chk_w("o_seg_md", SEG_W'(o_seg_md), SEG_W'(mq[0].md));
        chk_n("o_seg_sop", int'(o_seg_sop), int'(mq[0].sop));
        chk_n("o_seg_eop", int'(o_seg_eop), int'(mq[0].eop));
        chk_n("o_seg_err", int'(o_seg_err), int'(mq[0].err));
      end else begin
        chk_w("o_seg_data_empty", o_seg_data, '0);
        chk_n("o_seg_flags_empty", int'({o_seg_sop, o_seg_eop, o_seg_err}), 0);
      end
    end
  end

  task automatic tick();
    @(posedge cclk);
    model_step();
    @(negedge cclk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] s, input logic [2:0] e);
    i_seg_v = v; i_seg_sop = s; i_seg_eop = e;
    for (int l = 0; l < 3; l++) begin
      i_seg_data[l*SEG_W +: SEG_W] = mk_data(nid + l);
      i_seg_md[l*MD_W +: MD_W]     = mk_md(nid + l);
    end
    nid += 3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_pb_rdy = 1'b0; drive(3'b000, 3'b000, 3'b000);
    tick(); tick();
    chk_en = 1'b1;
    chk_n("rst_v", int'(o_seg_v), 0);
    chk_n("rst_count", int'(o_count), 0);
    chk_n("rst_drop", int'(o_drop_cnt), 0);
    chk_n("rst_ovf", int'(o_ovf), 0);
    rst = 1'b0;

    // 1: three-lane frame, drained in lane order
    i_pb_rdy = 1'b1; b = nid; drive(3'b111, 3'b001, 3'b100); tick();
    chk_n("t1_count3", int'(o_count), 3);
    chk_n("t1_sop", int'(o_seg_sop), 1);
    chk_w("t1_data0", o_seg_data, mk_data(b));
    drive(3'b000, 3'b000, 3'b000); tick();
    chk_n("t1_count2", int'(o_count), 2);
    chk_w("t1_data1", o_seg_data, mk_data(b + 1));
    tick();
    chk_n("t1_count1", int'(o_count), 1);
    chk_n("t1_eop", int'(o_seg_eop), 1);
    tick();
    chk_n("t1_count0", int'(o_count), 0);

    // 2: gap squeeze
    i_pb_rdy = 1'b0; b = nid; drive(3'b101, 3'b101, 3'b101); tick();
    chk_n("t2_count", int'(o_count), 2);
    chk_w("t2_head0", o_seg_data, mk_data(b));
    drive(3'b000, 3'b000, 3'b000); i_pb_rdy = 1'b1; tick();
    chk_w("t2_head1", o_seg_data, mk_data(b + 2));
    tick();

    // 3: fill with an open frame, overflow, abort marker
    i_pb_rdy = 1'b0; drive(3'b111, 3'b001, 3'b000); tick();
    repeat (4) begin drive(3'b111, 3'b000, 3'b000); tick(); end
    chk_n("t3_count15", int'(o_count), 15);
    drive(3'b111, 3'b000, 3'b000); tick();
    chk_n("t3_ovf", int'(o_ovf), 1);
    chk_n("t3_drop3", int'(o_drop_cnt), 3);
    drive(3'b000, 3'b000, 3'b000); tick();
    chk_n("t3_count16", int'(o_count), 16);
    i_pb_rdy = 1'b1;
    repeat (15) tick();
    chk_n("t3_abort_err", int'(o_seg_err), 1);
    chk_n("t3_abort_eop", int'(o_seg_eop), 1);
    chk_w("t3_abort_data", o_seg_data, '0);

    // 4: resync on mid-group sop
    b = nid; drive(3'b111, 3'b010, 3'b100); tick();
    chk_n("t4_drop4", int'(o_drop_cnt), 4);
    chk_n("t4_no_ovf", int'(o_ovf), 0);
    chk_n("t4_count2", int'(o_count), 2);
    chk_w("t4_head", o_seg_data, mk_data(b + 1));
    drive(3'b000, 3'b000, 3'b000); tick(); tick();

    // 5: full FIFO with pop, push not credited
    i_pb_rdy = 1'b0;
    repeat (5) begin drive(3'b111, 3'b111, 3'b111); tick(); end
    drive(3'b001, 3'b001, 3'b001); tick();
    chk_n("t5_full", int'(o_count), 16);
    i_pb_rdy = 1'b1; drive(3'b001, 3'b001, 3'b001); tick();
    chk_n("t5_count15", int'(o_count), 15);
    chk_n("t5_ovf", int'(o_ovf), 1);
    chk_n("t5_drop5", int'(o_drop_cnt), 5);
    drive(3'b000, 3'b000, 3'b000); tick();
    repeat (14) tick();
    chk_n("t5_abort_head", int'(o_seg_err), 1);
    tick();
    b = nid; drive(3'b001, 3'b001, 3'b001); tick();
    chk_w("t5_resync", o_seg_data, mk_data(b));
    drive(3'b000, 3'b000, 3'b000); tick();

    // 6: reset mid-frame
    i_pb_rdy = 1'b0; drive(3'b111, 3'b001, 3'b000); tick();
    drive(3'b111, 3'b000, 3'b000); tick();
    drive(3'b001, 3'b000, 3'b000); tick();
    chk_n("t6_count7", int'(o_count), 7);
    rst = 1'b1; drive(3'b000, 3'b000, 3'b000); tick();
    chk_n("t6_v", int'(o_seg_v), 0);
    chk_n("t6_count", int'(o_count), 0);
    chk_n("t6_drop", int'(o_drop_cnt), 0);
    rst = 1'b0; i_pb_rdy = 1'b1; b = nid; drive(3'b011, 3'b001, 3'b010); tick();
    chk_n("t6_new_sop", int'(o_seg_sop), 1);
    chk_n("t6_new_err", int'(o_seg_err), 0);
    chk_w("t6_new_data", o_seg_data, mk_data(b));
    drive(3'b000, 3'b000, 3'b000); tick(); tick();

    // 7: drop counter saturation
    i_pb_rdy = 1'b0;
    repeat (6) begin drive(3'b111, 3'b111, 3'b111); tick(); end
    chk_n("t7_drop3", int'(o_drop_cnt), 3);
    repeat (4) begin drive(3'b111, 3'b000, 3'b000); tick(); end
    chk_n("t7_drop15", int'(o_drop_cnt), 15);
    drive(3'b111, 3'b000, 3'b000); tick();
    chk_n("t7_sat", int'(o_drop_cnt), 15);
    chk_n("t7_no_ovf", int'(o_ovf), 0);
    drive(3'b000, 3'b000, 3'b000); i_pb_rdy = 1'b1;
    repeat (16) tick();
    chk_n("t7_empty", int'(o_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
